// File: rtl/rom_boot_sequencer_if.sv
// Boot-source stream plus Hack SoC rom_loader handshake, bundled for rom_boot_sequencer.
// A source word transfers on a clock edge where in_valid && in_ready. A loader word transfers
// when rom_loader_sck rises; rom_loader_ack rises in reply, then falls after sck falls.
interface rom_boot_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  rom_loader_load;
    logic                  rom_loader_sck;
    logic [DATA_WIDTH-1:0] rom_loader_data;
    logic                  rom_loader_ack;

    modport master (
        input  in_valid, in_data, rom_loader_ack,
        output in_ready, rom_loader_load, rom_loader_sck, rom_loader_data
    );

    modport slave (
        output in_valid, in_data, rom_loader_ack,
        input  in_ready, rom_loader_load, rom_loader_sck, rom_loader_data
    );
endinterface

// File: rtl/rom_boot_sequencer.sv
// Streams boot words from a valid/ready source into the Hack SoC rom_loader port, holding the
// CPU in reset until the image is written. Define ROM_BOOT_TIMEOUT_EN to enable the ack timeout.
module rom_boot_sequencer #(
    parameter int DATA_WIDTH     = 16,
    parameter int COUNT_WIDTH    = 16,
    parameter int SETUP_CYCLES   = 2,
    parameter int HOLD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] word_count,
    rom_boot_sequencer_if.master   bus,
    output logic                   hack_external_reset,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] words_loaded,
    output logic                   error,
    output logic [3:0]             dbg_state
);

    localparam int CNT_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_SETUP  = 4'd1,
        S_FETCH  = 4'd2,
        S_DSETUP = 4'd3,
        S_SCK_HI = 4'd4,
        S_SCK_LO = 4'd5,
        S_FINISH = 4'd6,
`ifdef ROM_BOOT_TIMEOUT_EN
        S_DONE   = 4'd7,
        S_ERROR  = 4'd8
`else
        S_DONE   = 4'd7
`endif
    } state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [COUNT_WIDTH-1:0]  count_q, count_n;
    logic [COUNT_WIDTH-1:0]  wl_n, wl_inc;
    logic                    in_ready_q, in_ready_n;
    logic                    load_q, load_n;
    logic                    sck_q, sck_n;
    logic [DATA_WIDTH-1:0]   data_q, data_n;
    logic                    hrst_n;
    logic                    busy_n, done_n;
    logic                    launch;

`ifdef ROM_BOOT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic          error_q, error_n;
`endif

    // Saturating increment: words_loaded never passes the latched count.
    assign wl_inc = (words_loaded == count_q) ? words_loaded : words_loaded + COUNT_WIDTH'(1);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        count_n    = count_q;
        wl_n       = words_loaded;
        in_ready_n = in_ready_q;
        load_n     = load_q;
        sck_n      = sck_q;
        data_n     = data_q;
        hrst_n     = hack_external_reset;
        busy_n     = busy;
        done_n     = done;
        launch     = 1'b0;
`ifdef ROM_BOOT_TIMEOUT_EN
        tmo_n      = tmo_cnt;
        error_n    = error_q;
`endif
        case (state)
            S_IDLE: launch = start;
            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_n = '0;
                    if (count_q == '0) begin
                        state_n = S_FINISH;
                    end else begin
                        state_n    = S_FETCH;
                        in_ready_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_FETCH: begin
                if (bus.in_valid) begin
                    data_n     = bus.in_data;
                    in_ready_n = 1'b0;
                    cnt_n      = '0;
                    state_n    = S_DSETUP;
                end
            end
            S_DSETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_n = S_SCK_HI;
                    sck_n   = 1'b1;
`ifdef ROM_BOOT_TIMEOUT_EN
                    tmo_n   = '0;
`endif
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_SCK_HI: begin
                if (bus.rom_loader_ack) begin
                    sck_n   = 1'b0;
                    state_n = S_SCK_LO;
`ifdef ROM_BOOT_TIMEOUT_EN
                    tmo_n   = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n = S_ERROR;
                    sck_n   = 1'b0;
                    load_n  = 1'b0;
                    busy_n  = 1'b0;
                    error_n = 1'b1;
                end else begin
                    tmo_n = tmo_cnt + TW'(1);
`endif
                end
            end
            S_SCK_LO: begin
                if (!bus.rom_loader_ack) begin
                    wl_n = wl_inc;
                    if (wl_inc == count_q) begin
                        state_n = S_FINISH;
                        cnt_n   = '0;
                    end else begin
                        state_n    = S_FETCH;
                        in_ready_n = 1'b1;
                    end
`ifdef ROM_BOOT_TIMEOUT_EN
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n = S_ERROR;
                    load_n  = 1'b0;
                    busy_n  = 1'b0;
                    error_n = 1'b1;
                end else begin
                    tmo_n = tmo_cnt + TW'(1);
`endif
                end
            end
            S_FINISH: begin
                if (cnt == HOLD_LAST) begin
                    state_n = S_DONE;
                    load_n  = 1'b0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_DONE: begin
                // CPU release lands one cycle after load drops.
                done_n = 1'b1;
                busy_n = 1'b0;
                hrst_n = 1'b0;
                launch = start;
            end
`ifdef ROM_BOOT_TIMEOUT_EN
            S_ERROR: launch = start;
`endif
            default: state_n = S_IDLE;
        endcase

        if (launch) begin
            state_n    = S_SETUP;
            cnt_n      = '0;
            count_n    = word_count;
            wl_n       = '0;
            in_ready_n = 1'b0;
            load_n     = 1'b1;
            sck_n      = 1'b0;
            hrst_n     = 1'b1;
            busy_n     = 1'b1;
            done_n     = 1'b0;
`ifdef ROM_BOOT_TIMEOUT_EN
            error_n    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= S_IDLE;
            cnt                 <= '0;
            count_q             <= '0;
            words_loaded        <= '0;
            in_ready_q          <= 1'b0;
            load_q              <= 1'b0;
            sck_q               <= 1'b0;
            data_q              <= '0;
            hack_external_reset <= 1'b1;
            busy                <= 1'b0;
            done                <= 1'b0;
`ifdef ROM_BOOT_TIMEOUT_EN
            tmo_cnt             <= '0;
            error_q             <= 1'b0;
`endif
        end else begin
            state               <= state_n;
            cnt                 <= cnt_n;
            count_q             <= count_n;
            words_loaded        <= wl_n;
            in_ready_q          <= in_ready_n;
            load_q              <= load_n;
            sck_q               <= sck_n;
            data_q              <= data_n;
            hack_external_reset <= hrst_n;
            busy                <= busy_n;
            done                <= done_n;
`ifdef ROM_BOOT_TIMEOUT_EN
            tmo_cnt             <= tmo_n;
            error_q             <= error_n;
`endif
        end
    end

`ifdef ROM_BOOT_TIMEOUT_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign bus.in_ready        = in_ready_q;
    assign bus.rom_loader_load = load_q;
    assign bus.rom_loader_sck  = sck_q;
    assign bus.rom_loader_data = data_q;
    assign dbg_state           = state;

endmodule

// File: tb/tb_rom_boot_sequencer.sv
// Self-checking bench for rom_boot_sequencer: SoC ack model, source driver, word scoreboard.
module tb_rom_boot_sequencer;
  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] word_count = '0;
  logic          hack_rst, busy, done, error;
  logic [CW-1:0] words_loaded;
  logic [3:0]    dbg_state;

  rom_boot_sequencer_if #(.DATA_WIDTH(DW)) sif ();

  rom_boot_sequencer #(
    .DATA_WIDTH(DW), .COUNT_WIDTH(CW), .SETUP_CYCLES(SETUP),
    .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .word_count(word_count),
    .bus(sif), .hack_external_reset(hack_rst), .busy(busy), .done(done),
    .words_loaded(words_loaded), .error(error), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // SoC model: ack follows sck two clocks late unless stuck low
  logic sck_d1 = 1'b0, sck_d2 = 1'b0;
  bit   ack_en = 1'b1;
  always @(posedge clk) begin
    sck_d1 <= sif.rom_loader_sck;
    sck_d2 <= sck_d1;
  end
  assign sif.rom_loader_ack = ack_en & sck_d2;

  // scoreboard
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];
  logic [DW-1:0] data_at_rise;
  bit            sck_prev = 1'b0;
  int pulses, unstable, ctx_bad, rdy_seen, load_cycles;
  int total = 0;
  int passed = 0;

  always @(negedge clk) begin
    if (sif.rom_loader_sck && !sck_prev) begin
      obs_q.push_back(sif.rom_loader_data);
      data_at_rise = sif.rom_loader_data;
      pulses++;
      if (!(sif.rom_loader_load && hack_rst && busy)) ctx_bad++;
    end
    if (sif.rom_loader_sck && sif.rom_loader_data !== data_at_rise) unstable++;
    if (sif.in_ready) rdy_seen++;
    if (sif.rom_loader_load) load_cycles++;
    sck_prev = sif.rom_loader_sck;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    pulses = 0; unstable = 0; ctx_bad = 0; rdy_seen = 0; load_cycles = 0;
  endtask

  // driver tasks
  task automatic start_session(input int n);
    @(negedge clk);
    word_count = CW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_start(input string tag);
    check({tag, "_start_hrst"}, hack_rst, 1);
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_done"}, done, 0);
    check({tag, "_start_wl"}, words_loaded, 0);
    check({tag, "_start_load"}, sif.rom_loader_load, 1);
    check({tag, "_start_err"}, error, 0);
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int gap, output bit ok);
    ok = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    sif.in_valid = 1'b1;
    sif.in_data  = w;
    for (int i = 0; i < 400; i++) begin
      if (sif.in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
    sif.in_valid = 1'b0;
    if (ok) exp_q.push_back(w);
  endtask

  task automatic pulse_ignored_start();
    @(negedge clk);
    word_count = CW'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_session(input string tag, input int n);
    int waited;
    waited = 0;
    while (done !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_hrst"}, hack_rst, 0);
    check({tag, "_load"}, sif.rom_loader_load, 0);
    check({tag, "_words_loaded"}, words_loaded, n);
    check({tag, "_sck_pulses"}, pulses, n);
    check({tag, "_accepted"}, exp_q.size(), n);
    check({tag, "_observed"}, obs_q.size(), n);
    check({tag, "_data_unstable"}, unstable, 0);
    check({tag, "_sck_context"}, ctx_bad, 0);
    for (int i = 0; i < n && i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  initial begin
    logic [DW-1:0] dir_words[3];
    bit ok;
    int n, cnt;
    bit found;

    sif.in_valid = 1'b0;
    sif.in_data  = '0;
    dir_words[0] = 16'hA5A5;
    dir_words[1] = 16'h0001;
    dir_words[2] = 16'hFFFF;

    // reset values
    #12;
    check("rst_hrst", hack_rst, 1);
    check("rst_load", sif.rom_loader_load, 0);
    check("rst_sck", sif.rom_loader_sck, 0);
    check("rst_data", sif.rom_loader_data, 0);
    check("rst_in_ready", sif.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wl", words_loaded, 0);
    check("rst_err", error, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // directed three-word image, back-to-back source
    clear_sb();
    start_session(3);
    check_start("dir");
    for (int i = 0; i < 3; i++) begin
      send_word(dir_words[i], 0, ok);
      check($sformatf("dir_accept%0d", i), ok, 1);
    end
    finish_session("dir", 3);

    // source gaps of 5 clocks; restart from DONE
    clear_sb();
    start_session(4);
    check_start("gap");
    for (int i = 0; i < 4; i++) begin
      send_word(DW'($urandom), 5, ok);
      check($sformatf("gap_accept%0d", i), ok, 1);
    end
    finish_session("gap", 4);

    // empty image
    clear_sb();
    start_session(0);
    check_start("zero");
    finish_session("zero", 0);
    check("zero_load_cycles", load_cycles, SETUP + HOLD);
    check("zero_in_ready_seen", rdy_seen, 0);

    // randomized images with a start pulse that must be ignored mid-session
    for (int s = 0; s < 2; s++) begin
      clear_sb();
      n = $urandom_range(4, 8);
      start_session(n);
      check_start($sformatf("rnd%0d", s));
      for (int i = 0; i < n; i++) begin
        send_word(DW'($urandom), $urandom_range(0, 6), ok);
        check($sformatf("rnd%0d_accept%0d", s, i), ok, 1);
        if (i == 1) begin
          pulse_ignored_start();
          check($sformatf("rnd%0d_busy_ignored_start", s), busy, 1);
        end
      end
      finish_session($sformatf("rnd%0d", s), n);
    end

    // reset while sck is high for the third word
    clear_sb();
    start_session(4);
    for (int i = 0; i < 3; i++) begin
      send_word(DW'($urandom), 0, ok);
      check($sformatf("mid_accept%0d", i), ok, 1);
    end
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sif.rom_loader_sck && words_loaded == CW'(2)) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_reach_sck_hi", found, 1);
    for (int i = 0; i < 2 && i < obs_q.size(); i++)
      check($sformatf("mid_word%0d", i), obs_q[i], exp_q[i]);
    reset_n = 1'b0;
    #1;
    check("mid_rst_hrst", hack_rst, 1);
    check("mid_rst_load", sif.rom_loader_load, 0);
    check("mid_rst_sck", sif.rom_loader_sck, 0);
    check("mid_rst_data", sif.rom_loader_data, 0);
    check("mid_rst_in_ready", sif.in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_wl", words_loaded, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

`ifdef ROM_BOOT_TIMEOUT_EN
    // ack stuck low
    clear_sb();
    ack_en = 1'b0;
    start_session(1);
    send_word(16'h1234, 0, ok);
    check("tmo_accept", ok, 1);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sif.rom_loader_sck) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("tmo_sck_rise", found, 1);
    cnt = 0;
    while (!error && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("tmo_cycles", cnt, TMO);
    check("tmo_error", error, 1);
    check("tmo_load", sif.rom_loader_load, 0);
    check("tmo_sck", sif.rom_loader_sck, 0);
    check("tmo_hrst", hack_rst, 1);
    check("tmo_busy", busy, 0);
    ack_en = 1'b1;
    repeat (4) @(negedge clk);
    clear_sb();
    start_session(1);
    check("tmo_restart_err", error, 0);
    send_word(16'h4321, 0, ok);
    check("tmo_restart_accept", ok, 1);
    finish_session("tmo_restart", 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
